// File: rtl/pipelined_prefix_adder_if.sv
// Operand/result stream bundle for pipelined_prefix_adder: valid/ready
// beats in, valid/ready results out.
interface pipelined_prefix_adder_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, a, b, cin, sub, tag_in, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, tag_out
    );

    modport slave (
        input  in_valid, a, b, cin, sub, tag_in, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, tag_out
    );
endinterface

// File: rtl/pipelined_prefix_adder.sv
// Streaming Kogge-Stone adder/subtractor: generate/propagate, clog2(WIDTH)
// prefix levels and the sum XOR spread over STAGES registers, global stall.
module pipelined_prefix_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    pipelined_prefix_adder_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH);

    if (WIDTH < 2 || TAG_W < 1 || STAGES < 1 || STAGES > LEVELS + 1) begin : g_param_check
        $error("pipelined_prefix_adder: WIDTH/STAGES/TAG_W out of range");
    end

    // g/p hold the partial prefix groups; hs is the untouched half-sum for the final XOR
    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] hs;
        logic             cin;
        logic             a_msb;
        logic             b_msb;
        logic [TAG_W-1:0] tag;
    } beat_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } res_t;

    // First prefix level handled by stage s; stage s covers [lvl_lo(s), lvl_lo(s+1))
    function automatic int lvl_lo(input int s);
        return (s * LEVELS + STAGES - 1) / STAGES;
    endfunction

    // cin is folded into bit 0's generate, so WIDTH positions need only clog2(WIDTH) levels
    function automatic beat_t pre(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin, input logic sub, input logic [TAG_W-1:0] tag);
        beat_t            x;
        logic [WIDTH-1:0] be;
        be      = sub ? ~b : b;
        x.hs    = a ^ be;
        x.p     = x.hs;
        x.g     = a & be;
        x.g[0]  = x.g[0] | (x.hs[0] & cin);
        x.cin   = cin;
        x.a_msb = a[WIDTH-1];
        x.b_msb = be[WIDTH-1];
        x.tag   = tag;
        return x;
    endfunction

    function automatic beat_t levels(input beat_t x, input int lo, input int hi);
        beat_t            y;
        logic [WIDTH-1:0] g_prev;
        logic [WIDTH-1:0] p_prev;
        y = x;
        for (int k = 0; k < LEVELS; k++) begin
            if (k >= lo && k < hi) begin
                g_prev = y.g;
                p_prev = y.p;
                for (int i = (1 << k); i < WIDTH; i++) begin
                    y.g[i] = g_prev[i] | (p_prev[i] & g_prev[i - (1 << k)]);
                    y.p[i] = p_prev[i] & p_prev[i - (1 << k)];
                end
            end
        end
        return y;
    endfunction

    // After all levels g[i] is the carry out of bit i
    function automatic res_t fin(input beat_t x);
        res_t r;
        r.sum  = x.hs ^ {x.g[WIDTH-2:0], x.cin};
        r.cout = x.g[WIDTH-1];
        r.ovf  = (x.a_msb == x.b_msb) && (r.sum[WIDTH-1] != x.a_msb);
        r.zero = (r.sum == '0);
        r.tag  = x.tag;
        return r;
    endfunction

    logic            en;
    logic [STAGES:1] vld_pipe;
    beat_t           in_beat;
    res_t            res_q;

    assign en            = !vld_pipe[STAGES] || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.sum       = res_q.sum;
    assign bus.cout      = res_q.cout;
    assign bus.ovf       = res_q.ovf;
    assign bus.zero      = res_q.zero;
    assign bus.tag_out   = res_q.tag;

    assign in_beat = pre(bus.a, bus.b, bus.cin, bus.sub, bus.tag_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (en) begin
            vld_pipe[1] <= bus.in_valid;
            for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    if (STAGES == 1) begin : g_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                  res_q <= '0;
            else if (en && bus.in_valid) res_q <= fin(levels(in_beat, 0, LEVELS));
        end
    end else begin : g_multi
        beat_t beat_q [STAGES-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < STAGES - 1; s++) beat_q[s] <= '0;
            end else if (en) begin
                beat_q[0] <= levels(in_beat, lvl_lo(0), lvl_lo(1));
                for (int s = 1; s < STAGES - 1; s++)
                    beat_q[s] <= levels(beat_q[s-1], lvl_lo(s), lvl_lo(s + 1));
            end
        end

        // Output register only loads real beats, so it keeps the last result across bubbles
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                res_q <= '0;
            else if (en && vld_pipe[STAGES-1])
                res_q <= fin(levels(beat_q[STAGES-2], lvl_lo(STAGES - 1), LEVELS));
        end
    end
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: directed cases at (16,3) plus random
// streams at four WIDTH/STAGES points, all checked against an arithmetic model.
module tb_pipelined_prefix_adder;
    logic clk;
    int   n_cmp  = 0;
    int   n_mis  = 0;
    int   n_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Layout {tag, zero, ovf, cout, sum} from plain (w+1)-bit arithmetic
    function automatic logic [127:0] ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                               input logic cin, input logic sub, input logic [7:0] tg);
        logic [64:0] full;
        logic [63:0] mask, beff, s;
        logic        co, ov, z;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        beff = (sub ? ~b : b) & mask;
        full = {1'b0, a & mask} + {1'b0, beff} + 65'(cin);
        s    = full[63:0] & mask;
        co   = full[w];
        ov   = (a[w-1] == beff[w-1]) && (s[w-1] != a[w-1]);
        z    = (s == 64'd0);
        return {53'b0, tg, z, ov, co, s};
    endfunction

    // ---------------- directed instance (16,3) ----------------
    logic drst;
    pipelined_prefix_adder_if #(.WIDTH(16), .TAG_W(4)) dif ();
    pipelined_prefix_adder #(.WIDTH(16), .STAGES(3), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(drst), .bus(dif));

    task automatic d_beat(input string nm, input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic [3:0] tg, input logic [15:0] es,
                          input logic ec, input logic eo, input logic ez);
        int lat;
        @(negedge clk);
        dif.a = a; dif.b = b; dif.cin = cin; dif.sub = sub; dif.tag_in = tg;
        dif.in_valid = 1'b1; dif.out_ready = 1'b1;
        #1 chk($sformatf("%s_rdy", nm), 128'(dif.in_ready), 128'(1));
        @(negedge clk);
        dif.in_valid = 1'b0;
        lat = 1;
        while (!dif.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("%s_lat", nm), 128'(lat), 128'(3));
        chk($sformatf("%s_sum", nm), 128'(dif.sum), 128'(es));
        chk($sformatf("%s_cout", nm), 128'(dif.cout), 128'(ec));
        chk($sformatf("%s_ovf", nm), 128'(dif.ovf), 128'(eo));
        chk($sformatf("%s_zero", nm), 128'(dif.zero), 128'(ez));
        chk($sformatf("%s_tag", nm), 128'(dif.tag_out), 128'(tg));
    endtask

    task automatic d_backpressure();
        logic [127:0] q[$];
        logic [5:0]   pat = 6'b101001;
        int           idx = 0, got = 0;
        logic         pend = 1'b0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            @(negedge clk);
            dif.out_ready = pat[cyc % 6];
            if (!pend && idx < 8) begin
                dif.a = 16'($urandom); dif.b = 16'($urandom);
                dif.cin = 1'($urandom); dif.sub = 1'($urandom);
                dif.tag_in = 4'(idx); dif.in_valid = 1'b1; pend = 1'b1;
            end else if (!pend) begin
                dif.in_valid = 1'b0;
            end
            #1;
            chk("bp_in_ready", 128'(dif.in_ready), 128'(!dif.out_valid || dif.out_ready));
            if (dif.in_valid && dif.in_ready) begin
                q.push_back(ref_model(16, 64'(dif.a), 64'(dif.b), dif.cin, dif.sub, 8'(dif.tag_in)));
                idx++;
                pend = 1'b0;
            end
            if (dif.out_valid) begin
                if (q.size() == 0) chk("bp_extra_beat", 128'(q.size()), 128'(1));
                else chk("bp_result", {53'b0, 8'(dif.tag_out), dif.zero, dif.ovf, dif.cout, 64'(dif.sum)}, q[0]);
                if (dif.out_ready && q.size() > 0) begin
                    void'(q.pop_front());
                    got++;
                end
            end
        end
        dif.in_valid = 1'b0;
        chk("bp_count", 128'(got), 128'(8));
    endtask

    initial begin
        int stale = 0;
        dif.in_valid = 1'b0; dif.out_ready = 1'b1; dif.a = '0; dif.b = '0;
        dif.cin = 1'b0; dif.sub = 1'b0; dif.tag_in = '0;
        drst = 1'b0;
        #1;
        chk("rst_out_valid", 128'(dif.out_valid), 128'(0));
        chk("rst_in_ready", 128'(dif.in_ready), 128'(1));
        repeat (2) @(negedge clk);
        drst = 1'b1;

        // three beats in flight with the output stalled, then a one-cycle reset
        @(negedge clk);
        dif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dif.a = 16'(i + 16'h0100); dif.b = 16'h0011; dif.tag_in = 4'(i + 1); dif.in_valid = 1'b1;
            @(negedge clk);
        end
        dif.in_valid = 1'b0;
        chk("pre_rst_valid", 128'(dif.out_valid), 128'(1));
        drst = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(dif.out_valid), 128'(0));
        chk("mid_rst_outs", {dif.tag_out, dif.zero, dif.ovf, dif.cout, dif.sum}, 128'(0));
        chk("mid_rst_ready", 128'(dif.in_ready), 128'(1));
        @(negedge clk);
        drst = 1'b1;
        dif.out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            stale += int'(dif.out_valid);
        end
        chk("stale_beats", 128'(stale), 128'(0));
        d_beat("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 4'h9, 16'h0002, 1'b0, 1'b0, 1'b0);

        d_beat("add",      16'h1234, 16'h5678, 1'b0, 1'b0, 4'h5, 16'h68AC, 1'b0, 1'b0, 1'b0);
        d_beat("add_cin",  16'h1234, 16'h5678, 1'b1, 1'b0, 4'h6, 16'h68AD, 1'b0, 1'b0, 1'b0);
        d_beat("carry",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'h1, 16'h0000, 1'b1, 1'b0, 1'b1);
        d_beat("ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'h2, 16'h8000, 1'b0, 1'b1, 1'b0);
        d_beat("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 4'h3, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        d_beat("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 4'hA, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        d_beat("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b1, 4'hB, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        d_beat("sub_zero", 16'h1234, 16'h1234, 1'b1, 1'b1, 4'hC, 16'h0000, 1'b1, 1'b0, 1'b1);

        d_backpressure();
        n_done++;
    end

    // ---------------- random streams at four configurations ----------------
    for (genvar ci = 0; ci < 4; ci++) begin : g_rand
        localparam int W = (ci == 0) ? 16 : (ci == 1) ? 32 : (ci == 2) ? 8 : 64;
        localparam int S = (ci == 0) ? 3  : (ci == 1) ? 1  : (ci == 2) ? 4 : 7;

        logic rrst;
        pipelined_prefix_adder_if #(.WIDTH(W), .TAG_W(4)) rf ();
        pipelined_prefix_adder #(.WIDTH(W), .STAGES(S), .TAG_W(4)) u_dut (
            .clk(clk), .rst_n(rrst), .bus(rf));

        initial begin
            logic [127:0] q[$];
            logic [127:0] r;
            int sent = 0, got = 0, extra = 0;
            rf.in_valid = 1'b0; rf.out_ready = 1'b0; rf.a = '0; rf.b = '0;
            rf.cin = 1'b0; rf.sub = 1'b0; rf.tag_in = '0;
            rrst = 1'b0;
            repeat (3) @(negedge clk);
            rrst = 1'b1;
            for (int cyc = 0; cyc < 20000 && (sent < 2000 || q.size() > 0); cyc++) begin
                @(negedge clk);
                rf.in_valid  = (sent < 2000) && ($urandom_range(3) != 0);
                r = {$urandom, $urandom, $urandom, $urandom};
                rf.a = r[W-1:0];
                r = {$urandom, $urandom, $urandom, $urandom};
                rf.b = r[W-1:0];
                rf.cin       = 1'($urandom);
                rf.sub       = 1'($urandom);
                rf.tag_in    = 4'($urandom);
                rf.out_ready = ($urandom_range(3) != 0);
                #1;
                if (rf.in_valid && rf.in_ready) begin
                    q.push_back(ref_model(W, 64'(rf.a), 64'(rf.b), rf.cin, rf.sub, 8'(rf.tag_in)));
                    sent++;
                end
                if (rf.out_valid) begin
                    if (q.size() == 0) begin
                        if (rf.out_ready) extra++;
                    end else begin
                        chk($sformatf("rand_w%0d_s%0d", W, S),
                            {53'b0, 8'(rf.tag_out), rf.zero, rf.ovf, rf.cout, 64'(rf.sum)}, q[0]);
                        if (rf.out_ready) begin
                            void'(q.pop_front());
                            got++;
                        end
                    end
                end
            end
            rf.in_valid = 1'b0;
            chk($sformatf("rand_w%0d_sent", W), 128'(sent), 128'(2000));
            chk($sformatf("rand_w%0d_lost", W), 128'(got), 128'(sent));
            chk($sformatf("rand_w%0d_extra", W), 128'(extra), 128'(0));
            n_done++;
        end
    end

    initial begin
        int cyc = 0;
        while (n_done < 5 && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        if (n_done < 5) chk("timeout_done", 128'(n_done), 128'(5));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
